// File: rtl/pipelined_checked_csel_adder_if.sv
// Operand/result bus for the checked carry-select adder: producer beats in, results and error status out.
interface pipelined_checked_csel_adder_if #(
  parameter int unsigned WIDTH     = 60,
  parameter int unsigned ERR_CNT_W = 8
);
  // Operand beat
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 pa;
  logic                 pb;
  logic                 c_in;
  logic                 inj_fault;

  // Result beat
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     s;
  logic                 c_out;
  logic                 s_par;
  logic                 err;

  // Error bookkeeping
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 err_clear;

  // Producer/consumer side
  modport master (
    output in_valid, a, b, pa, pb, c_in, inj_fault, out_ready, err_clear,
    input  in_ready, out_valid, s, c_out, s_par, err, err_sticky, err_count
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, pa, pb, c_in, inj_fault, out_ready, err_clear,
    output in_ready, out_valid, s, c_out, s_par, err, err_sticky, err_count
  );
endinterface

// File: rtl/pipelined_checked_csel_adder.sv
// Pipelined carry-select adder with a complemented duplicate rail, operand parity checking,
// valid/ready flow control and sticky/saturating error reporting.
module pipelined_checked_csel_adder #(
  parameter int unsigned WIDTH     = 60,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned ERR_CNT_W = 8
) (
  input logic                           clk,
  input logic                           rst,
  pipelined_checked_csel_adder_if.slave bus
);

  // Carry-select block partition: sizes 2,2,4,4,6,6,... from the LSB, last block truncated.
  function automatic int unsigned blk_lo(input int unsigned k);
    int unsigned lo;
    lo = 0;
    for (int unsigned i = 0; i < k; i++) lo += 2 * (i / 2 + 1);
    return lo;
  endfunction

  function automatic int unsigned blk_w(input int unsigned k);
    int unsigned lo;
    int unsigned w;
    lo = blk_lo(k);
    w  = 2 * (k / 2 + 1);
    return (lo + w > WIDTH) ? (WIDTH - lo) : w;
  endfunction

  function automatic int unsigned num_blk();
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (blk_lo(i) < WIDTH) n = i + 1;
    end
    return n;
  endfunction

  localparam int unsigned NBLK = num_blk();
  localparam int unsigned LAST = STAGES - 1;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             sp;
    logic             err;
  } res_t;

  // Rail operands: index 0 is the true rail, index 1 the complemented duplicate.
  logic [1:0][WIDTH-1:0] op_a;
  logic [1:0][WIDTH-1:0] op_b;
  logic [1:0][WIDTH-1:0] rsum;
  logic [1:0]            rcin;
  logic [1:0]            rcout;
  logic [WIDTH-1:0]      dup_carry;

  assign op_a = {~bus.a, bus.a};
  assign op_b = {~bus.b, bus.b};
  assign rcin = {~bus.c_in, bus.c_in};

  // Two fully independent carry-select chains so a single fault cannot hit both rails.
  for (genvar r = 0; r < 2; r++) begin : g_rail
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
      localparam int unsigned LO = blk_lo(k);
      localparam int unsigned BW = blk_w(k);

      logic          ci;
      logic          co;
      logic [BW:0]   sum0;
      logic [BW:0]   sum1;
      logic [BW:0]   sel;

      if (k == 0) begin : g_head
        assign ci = rcin[r];
      end else begin : g_link
        assign ci = g_blk[k-1].co;
      end

      // Both carry-in variants computed up front; the incoming carry only drives the mux.
      assign sum0 = {1'b0, op_a[r][LO +: BW]} + {1'b0, op_b[r][LO +: BW]};
      assign sum1 = {1'b0, op_a[r][LO +: BW]} + {1'b0, op_b[r][LO +: BW]} + {{BW{1'b0}}, 1'b1};
      assign sel  = ci ? sum1 : sum0;
      assign co   = sel[BW];
      assign rsum[r][LO +: BW] = sel[BW-1:0];

      // Per-bit carries of the duplicate rail feed the sum-parity prediction.
      if (r == 1) begin : g_cv
        assign dup_carry[LO +: BW] = sel[BW-1:0] ^ op_a[r][LO +: BW] ^ op_b[r][LO +: BW];
      end
    end

    assign rcout[r] = g_blk[NBLK-1].co;
  end

  logic [WIDTH-1:0] s_true;
  logic [WIDTH-1:0] s_dup;
  logic             c_true;
  logic             c_dup;
  logic             dup_mis_c;
  logic             par_a_err_c;
  logic             par_b_err_c;
  logic             s_par_c;
  res_t             res_c;

  assign s_true = rsum[0];
  assign c_true = rcout[0];
  // Test hook: corrupt the duplicate rail so the checker can be exercised in system.
  assign s_dup  = rsum[1] ^ WIDTH'(bus.inj_fault);
  assign c_dup  = rcout[1];

  // Rails must be exact complements; any agreeing bit is a fault.
  assign dup_mis_c   = (|(s_true ~^ s_dup)) | (c_true == c_dup);
  assign par_a_err_c = bus.pa != (^bus.a);
  assign par_b_err_c = bus.pb != (^bus.b);

  // Duplicate-rail carries are the complement of the true carries, so invert before folding.
  assign s_par_c = bus.pa ^ bus.pb ^ (^(~dup_carry));

  assign res_c = '{s: s_true, c: c_true, sp: s_par_c, err: dup_mis_c | par_a_err_c | par_b_err_c};

  // Flow control: the whole pipe advances together whenever the output is free or being taken.
  logic               en_c;
  logic               accept_c;
  logic               deliver_c;
  logic               err_ev_c;
  logic [STAGES-1:0]  vld;
  res_t               stg [STAGES];
  logic               sticky;
  logic [ERR_CNT_W-1:0] cnt;

  assign en_c      = ~vld[LAST] | bus.out_ready;
  assign accept_c  = bus.in_valid & en_c;
  assign deliver_c = vld[LAST] & bus.out_ready;
  assign err_ev_c  = deliver_c & stg[LAST].err;

  // Result pipeline; bubbles travel with the data and payload only reloads on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int unsigned i = 0; i < STAGES; i++) stg[i] <= '0;
    end else if (en_c) begin
      vld[0] <= accept_c;
      if (accept_c) stg[0] <= res_c;
      for (int unsigned i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        stg[i] <= stg[i-1];
      end
    end
  end

  // Error bookkeeping; a clear in the same cycle as an erroneous delivery leaves that one counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (bus.err_clear) begin
      sticky <= err_ev_c;
      cnt    <= ERR_CNT_W'(err_ev_c);
    end else if (err_ev_c) begin
      sticky <= 1'b1;
      if (cnt != '1) cnt <= cnt + ERR_CNT_W'(1);
    end
  end

  assign bus.in_ready   = en_c;
  assign bus.out_valid  = vld[LAST];
  assign bus.s          = stg[LAST].s;
  assign bus.c_out      = stg[LAST].c;
  assign bus.s_par      = stg[LAST].sp;
  assign bus.err        = stg[LAST].err;
  assign bus.err_sticky = sticky;
  assign bus.err_count  = cnt;

endmodule

// File: tb/tb_pipelined_checked_csel_adder.sv
// Scoreboard bench: a 60-bit/2-stage instance for directed cases, a 17-bit/3-stage one for random traffic.
module tb_pipelined_checked_csel_adder;

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        sp;
    logic        e;
  } exp_t;

  logic clk;
  logic rst60;
  logic rst17;

  int   checks;
  int   errors;
  exp_t q [2][$];
  int   m_cnt [2];
  logic m_stk [2];
  int   deliv [2];
  int   acc17;

  pipelined_checked_csel_adder_if #(.WIDTH(60), .ERR_CNT_W(8)) b60 ();
  pipelined_checked_csel_adder_if #(.WIDTH(17), .ERR_CNT_W(8)) b17 ();

  pipelined_checked_csel_adder #(.WIDTH(60), .STAGES(2), .ERR_CNT_W(8)) dut60 (
    .clk(clk), .rst(rst60), .bus(b60)
  );
  pipelined_checked_csel_adder #(.WIDTH(17), .STAGES(3), .ERR_CNT_W(8)) dut17 (
    .clk(clk), .rst(rst17), .bus(b17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer addition, carries recovered as sum ^ a ^ b.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic pa, input logic pb, input logic inj);
    exp_t        m;
    logic [64:0] full;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    full = {1'b0, a} + {1'b0, b} + 65'(ci);
    m.s  = full[63:0] & mask;
    m.c  = full[w];
    m.sp = pa ^ pb ^ (^((m.s ^ a ^ b) & mask));
    m.e  = inj | (pa != (^(a & mask))) | (pb != (^(b & mask)));
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: per-cycle error status check, then pop-and-compare on every delivery.
  task automatic mon(input int id, input string nm, input logic r, input logic ov, input logic ordy,
                     input logic [63:0] s, input logic c, input logic sp, input logic e,
                     input logic stk, input int cnt, input logic clr);
    exp_t x;
    logic ev;
    if (r) begin
      q[id].delete();
      m_cnt[id] = 0;
      m_stk[id] = 1'b0;
      return;
    end
    chk($sformatf("%s err_sticky", nm), 64'(stk), 64'(m_stk[id]));
    chk($sformatf("%s err_count", nm), 64'(cnt), 64'(m_cnt[id]));
    ev = 1'b0;
    if (ov && ordy) begin
      checks++;
      if (q[id].size() == 0) begin
        errors++;
        $display("FAIL %s unexpected result: got s=%0h expected no delivery", nm, s);
      end else begin
        x = q[id].pop_front();
        deliv[id]++;
        chk($sformatf("%s s", nm), s, x.s);
        chk($sformatf("%s c_out", nm), 64'(c), 64'(x.c));
        chk($sformatf("%s s_par", nm), 64'(sp), 64'(x.sp));
        chk($sformatf("%s err", nm), 64'(e), 64'(x.e));
        ev = x.e;
      end
    end
    if (clr) begin
      m_cnt[id] = ev ? 1 : 0;
      m_stk[id] = ev;
    end else if (ev) begin
      m_stk[id] = 1'b1;
      if (m_cnt[id] < 255) m_cnt[id]++;
    end
  endtask

  // Issue side: every accepted beat pushes its expected result.
  always @(negedge clk) begin
    if (!rst60 && b60.in_valid && b60.in_ready)
      q[0].push_back(model(60, 64'(b60.a), 64'(b60.b), b60.c_in, b60.pa, b60.pb, b60.inj_fault));
    if (!rst17 && b17.in_valid && b17.in_ready) begin
      q[1].push_back(model(17, 64'(b17.a), 64'(b17.b), b17.c_in, b17.pa, b17.pb, b17.inj_fault));
      acc17++;
    end
  end

  always @(negedge clk)
    mon(0, "w60", rst60, b60.out_valid, b60.out_ready, 64'(b60.s), b60.c_out, b60.s_par, b60.err,
        b60.err_sticky, 32'(b60.err_count), b60.err_clear);

  always @(negedge clk)
    mon(1, "w17", rst17, b17.out_valid, b17.out_ready, 64'(b17.s), b17.c_out, b17.s_par, b17.err,
        b17.err_sticky, 32'(b17.err_count), b17.err_clear);

  task automatic send60(input logic [59:0] a, input logic [59:0] b, input logic ci, input logic inj,
                        input logic pa_flip, input logic pb_flip);
    logic ok;
    b60.a         = a;
    b60.b         = b;
    b60.c_in      = ci;
    b60.pa        = (^a) ^ pa_flip;
    b60.pb        = (^b) ^ pb_flip;
    b60.inj_fault = inj;
    b60.in_valid  = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (b60.in_ready) ok = 1'b1;
      tick();
    end
    b60.in_valid  = 1'b0;
    b60.inj_fault = 1'b0;
    chk("w60 beat accepted", 64'(ok), 64'd1);
  endtask

  task automatic drain(input int id);
    for (int n = 0; n < 100 && q[id].size() != 0; n++) tick();
    chk($sformatf("drain %0d pending", id), 64'(q[id].size()), 64'd0);
  endtask

  initial begin
    int d0;
    checks = 0; errors = 0; acc17 = 0;
    rst60 = 1'b1; rst17 = 1'b1;
    b60.in_valid = 0; b60.a = '0; b60.b = '0; b60.pa = 0; b60.pb = 0; b60.c_in = 0;
    b60.inj_fault = 0; b60.out_ready = 1; b60.err_clear = 0;
    b17.in_valid = 0; b17.a = '0; b17.b = '0; b17.pa = 0; b17.pb = 0; b17.c_in = 0;
    b17.inj_fault = 0; b17.out_ready = 1; b17.err_clear = 0;
    repeat (3) @(posedge clk);
    #1;
    rst60 = 1'b0; rst17 = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst in_ready", 64'(b60.in_ready), 64'd1);
    chk("rst out_valid", 64'(b60.out_valid), 64'd0);
    chk("rst s", 64'(b60.s), 64'd0);
    chk("rst c_out", 64'(b60.c_out), 64'd0);
    chk("rst s_par", 64'(b60.s_par), 64'd0);
    chk("rst err", 64'(b60.err), 64'd0);
    chk("rst17 out_valid", 64'(b17.out_valid), 64'd0);
    tick();

    // All-ones plus one wraps to zero with carry out, two cycles later
    send60(60'hFFF_FFFF_FFFF_FFFF, 60'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat out_valid@1", 64'(b60.out_valid), 64'd0);
    @(negedge clk);
    chk("lat out_valid@2", 64'(b60.out_valid), 64'd1);
    chk("wrap s", 64'(b60.s), 64'd0);
    chk("wrap c_out", 64'(b60.c_out), 64'd1);
    chk("wrap err", 64'(b60.err), 64'd0);
    tick();
    drain(0);

    // Back-to-back beats against a 3-cycle stall
    d0 = deliv[0];
    fork
      begin
        send60(60'd10, 60'd20, 1'b0, 1'b0, 1'b0, 1'b0);
        send60(60'h800_0000_0000_0000, 60'h800_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        send60(60'h123_4567_89AB_CDEF, 60'hFED_CBA9_8765_4321, 1'b0, 1'b0, 1'b0, 1'b0);
        send60(60'd0, 60'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      begin
        b60.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall in_ready", 64'(b60.in_ready), 64'd0);
        tick();
        b60.out_ready = 1'b1;
      end
    join
    drain(0);
    chk("stall delivered", 64'(deliv[0] - d0), 64'd4);

    // Wrong parity on a
    send60(60'd3, 60'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(0);
    @(negedge clk);
    chk("pa err_sticky", 64'(b60.err_sticky), 64'd1);
    chk("pa err_count", 64'(b60.err_count), 64'd1);
    tick();

    // Injected duplicate-rail fault, then a clean beat
    send60(60'd5, 60'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    send60(60'd9, 60'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(0);
    @(negedge clk);
    chk("inj err_sticky", 64'(b60.err_sticky), 64'd1);
    chk("inj err_count", 64'(b60.err_count), 64'd2);
    tick();

    // Counter saturation
    repeat (253) send60(60'({$urandom, $urandom}), 60'({$urandom, $urandom}), 1'b0, 1'b0, 1'b0, 1'b1);
    drain(0);
    @(negedge clk);
    chk("sat err_count 255", 64'(b60.err_count), 64'd255);
    tick();
    send60(60'd1, 60'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(0);
    @(negedge clk);
    chk("sat hold 255", 64'(b60.err_count), 64'd255);
    tick();

    // Clear coinciding with an erroneous delivery
    send60(60'd4, 60'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 20 && !b60.out_valid; n++) tick();
    b60.err_clear = 1'b1;
    tick();
    b60.err_clear = 1'b0;
    @(negedge clk);
    chk("clr+err count", 64'(b60.err_count), 64'd1);
    chk("clr+err sticky", 64'(b60.err_sticky), 64'd1);
    tick();

    // Reset with two beats in flight
    b60.out_ready = 1'b0;
    send60(60'd11, 60'd22, 1'b0, 1'b0, 1'b0, 1'b0);
    send60(60'd33, 60'd44, 1'b0, 1'b0, 1'b0, 1'b0);
    rst60 = 1'b1;
    tick();
    rst60 = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", 64'(b60.out_valid), 64'd0);
    chk("midrst err_count", 64'(b60.err_count), 64'd0);
    chk("midrst err_sticky", 64'(b60.err_sticky), 64'd0);
    chk("midrst in_ready", 64'(b60.in_ready), 64'd1);
    tick();
    b60.out_ready = 1'b1;
    repeat (10) tick();

    // Random traffic on the 17-bit, 3-stage instance
    for (int cyc = 0; cyc < 40000 && acc17 < 10000; cyc++) begin
      b17.in_valid  = ($urandom_range(3) != 0);
      b17.a         = 17'($urandom);
      b17.b         = 17'($urandom);
      b17.c_in      = 1'($urandom);
      b17.pa        = (^b17.a) ^ ($urandom_range(15) == 0);
      b17.pb        = (^b17.b) ^ ($urandom_range(15) == 0);
      b17.inj_fault = ($urandom_range(15) == 0);
      b17.out_ready = ($urandom_range(3) != 0);
      b17.err_clear = ($urandom_range(31) == 0);
      tick();
    end
    b17.in_valid = 1'b0; b17.inj_fault = 1'b0; b17.err_clear = 1'b0; b17.out_ready = 1'b1;
    drain(1);
    chk("random beats issued", 64'(acc17 >= 10000), 64'd1);
    chk("random delivered", 64'(deliv[1]), 64'(acc17));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
